// File: rtl/score_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner for a BCD score, with frame-aligned
// display updates, leading-zero blanking and a sticky non-BCD error flag.
module score_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   pend;
  logic          pend_flag;
  logic [15:0]   disp;

  logic          tick;
  logic          boundary;
  logic [15:0]   disp_nxt;
  logic          bad_nxt;
  logic [3:0]    digit;
  logic [3:0]    lz;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0111111;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Frame boundary and the value the display register takes there.
  always_comb begin
    tick     = (cnt == CNT_MAX);
    boundary = tick && (idx == 2'd3);
    disp_nxt = disp;
    if (boundary) begin
      if (load)           disp_nxt = bcd_in;
      else if (pend_flag) disp_nxt = pend;
    end
    bad_nxt = (disp_nxt[15:12] > 4'd9) || (disp_nxt[11:8] > 4'd9) ||
              (disp_nxt[7:4]   > 4'd9) || (disp_nxt[3:0]  > 4'd9);
  end

  // Digit selection, leading-zero blanking and segment decode for the active slot.
  always_comb begin
    digit = disp[3:0];
    case (idx)
      2'd1:    digit = disp[7:4];
      2'd2:    digit = disp[11:8];
      2'd3:    digit = disp[15:12];
      default: digit = disp[3:0];
    endcase
    lz[3]   = (disp[15:12] == 4'd0);
    lz[2]   = lz[3] && (disp[11:8] == 4'd0);
    lz[1]   = lz[2] && (disp[7:4] == 4'd0);
    lz[0]   = 1'b0;
    blank   = (BLANK_LZ != 0) && lz[idx];
    an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_nxt = blank ? 7'b1111111 : decode(digit);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      pend       <= 16'd0;
      pend_flag  <= 1'b0;
      disp       <= 16'd0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx + 2'd1;
      disp <= disp_nxt;
      // A load coinciding with the boundary bypasses the pending register.
      if (boundary) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pend      <= bcd_in;
        pend_flag <= 1'b1;
      end
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= boundary;
      if (boundary && bad_nxt) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_seg_scanner.sv
// Self-checking bench for score_seg_scanner: directed scenarios plus random
// loads/resets, compared every cycle against a frame-position reference model.
module tb_score_seg_scanner;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 4 * DIV;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        err;

  always #5 Clk = ~Clk;

  score_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: position within the frame plus shown/pending values.
  int          m_t = 0;
  logic [15:0] m_disp = 16'd0;
  logic [15:0] m_pend = 16'd0;
  logic        m_pflag = 1'b0;
  logic        m_err = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_fd = 1'b0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic l, input logic [15:0] b);
    int          slot;
    logic [15:0] upper;
    logic        bnd;
    if (!r) begin
      m_t = 0; m_disp = 16'd0; m_pend = 16'd0; m_pflag = 1'b0;
      m_err = 1'b0; m_an = 4'hF; m_seg = 7'h7F; m_fd = 1'b0;
    end else begin
      slot  = m_t / DIV;
      upper = m_disp >> (4 * slot);
      if (slot != 0 && upper == 16'd0) begin
        m_an = 4'hF; m_seg = 7'h7F;
      end else begin
        m_an  = ~(4'(1) << slot);
        m_seg = seg_of(upper[3:0]);
      end
      bnd  = (m_t == FRAME - 1);
      m_fd = bnd;
      if (bnd) begin
        if (l) m_disp = b;
        else if (m_pflag) m_disp = m_pend;
        m_pflag = 1'b0;
        if (has_bad(m_disp)) m_err = 1'b1;
      end else if (l) begin
        m_pend = b; m_pflag = 1'b1;
      end
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [15:0] b);
    @(negedge Clk);
    Reset_n = r; load = l; bcd_in = b;
    @(posedge Clk);
    model_edge(r, l, b);
    #1;
    chk("an", 16'(an), 16'(m_an));
    chk("seg", 16'(seg), 16'(m_seg));
    chk("frame_done", 16'(frame_done), 16'(m_fd));
    chk("err", 16'(err), 16'(m_err));
  endtask

  task automatic to_pos(input int p);
    for (int i = 0; i < FRAME && m_t != p; i++) cyc(1'b1, 1'b0, 16'd0);
  endtask

  // Walk one boundary and the following frame, checking each slot's start.
  task automatic frame_check(input string tag, input logic [15:0] ans, input logic [27:0] segs);
    to_pos(FRAME - 1);
    cyc(1'b1, 1'b0, 16'd0);
    chk({tag, "_fd"}, 16'(frame_done), 16'd1);
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, 1'b0, 16'd0);
      chk({tag, "_an"}, 16'(an), 16'(ans[4*s +: 4]));
      chk({tag, "_seg"}, 16'(seg), 16'(segs[7*s +: 7]));
      for (int k = 1; k < DIV; k++) cyc(1'b1, 1'b0, 16'd0);
    end
  endtask

  initial begin
    logic [15:0] rb;

    // Reset state.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_fd", 16'(frame_done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);

    // No load: digit 0 shows "0" for one slot, then three blank slots.
    cyc(1'b1, 1'b0, 16'd0);
    chk("idle_an0", 16'(an), 16'hE);
    chk("idle_seg0", 16'(seg), 16'h40);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      chk("idle_an", 16'(an), (i < 4) ? 16'hE : 16'hF);
    end

    // Mid-frame load of 1234.
    to_pos(6);
    cyc(1'b1, 1'b1, 16'h1234);
    frame_check("l1234", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});

    // Leading-zero blanking on 0042.
    to_pos(3);
    cyc(1'b1, 1'b1, 16'h0042);
    frame_check("l0042", 16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h24});

    // Two loads in one frame: last wins.
    to_pos(2);
    cyc(1'b1, 1'b1, 16'h0001);
    to_pos(9);
    cyc(1'b1, 1'b1, 16'h0009);
    frame_check("last_wins", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h10});

    // Load coincident with the boundary is applied immediately.
    to_pos(FRAME - 1);
    cyc(1'b1, 1'b1, 16'h0008);
    chk("coin_fd", 16'(frame_done), 16'd1);
    cyc(1'b1, 1'b0, 16'd0);
    chk("coin_an", 16'(an), 16'hE);
    chk("coin_seg", 16'(seg), 16'h00);
    frame_check("coin_hold", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h00});

    // Non-BCD digit shows a dash and sets the sticky error.
    chk("err_before", 16'(err), 16'd0);
    to_pos(5);
    cyc(1'b1, 1'b1, 16'h00A5);
    frame_check("l00A5", 16'hFFDE, {7'h7F, 7'h7F, 7'h3F, 7'h12});
    chk("err_set", 16'(err), 16'd1);
    frame_check("l00A5_hold", 16'hFFDE, {7'h7F, 7'h7F, 7'h3F, 7'h12});
    chk("err_sticky", 16'(err), 16'd1);

    // Reset mid-frame with a load pending: pending value discarded.
    to_pos(4);
    cyc(1'b1, 1'b1, 16'h0777);
    to_pos(8);
    cyc(1'b0, 1'b0, 16'd0);
    chk("mrst_an", 16'(an), 16'hF);
    chk("mrst_seg", 16'(seg), 16'h7F);
    chk("mrst_err", 16'(err), 16'd0);
    chk("mrst_fd", 16'(frame_done), 16'd0);
    frame_check("mrst_after", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Random loads, values (some non-BCD) and occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 2) == 0) rb = rb & 16'h00FF;
      end else begin
        rb = 16'($urandom);
      end
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 11) == 0), rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
